pipeline_ctrl: RTL and testbench

Central stall/flush scheduler for the five-stage pipeline (IF, ID, EX, MA, WB). Each cycle it takes the branch/jump resolution from the EXMA register, the load-use hazard check between ID and IDEX, and the data-memory handshake of the MA stage. From these it drives every pipeline-register write enable, every bubble/flush strobe and the PC-redirect select. A registered FSM freezes the pipeline while data memory is not ready and halts it permanently on a memory timeout.

---
 rtl/pipe_ctrl_pkg.sv | 34 +++
 rtl/pipeline_ctrl_load_use_detect.sv | 16 +
 rtl/pipeline_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush scheduler: next-PC select
// codes, FSM encodings and the branch-resolution helper.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        SEL_PC4  = 3'd0,
        SEL_BLT  = 3'd1,
        SEL_BEQ  = 3'd2,
        SEL_JAL  = 3'd3,
        SEL_JALR = 3'd4
    } addr_sel_e;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } pipe_state_e;

    // Codes 5..7 fall to the default arm and behave like PC+4.
    function automatic logic branch_taken(input logic [2:0] sel,
                                          input logic       less,
                                          input logic       zero);
        logic taken;
        case (sel)
            SEL_BLT:  taken = less;
            SEL_BEQ:  taken = zero;
            SEL_JAL:  taken = 1'b1;
            SEL_JALR: taken = 1'b1;
            default:  taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Combinational load-use comparator between the instruction in ID and a load
// in IDEX; x0 never creates a dependency. Also usable by the forwarding unit.
module load_use_detect (
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       use_rs1,
    input  logic       use_rs2,
    input  logic [4:0] rd,
    input  logic       mem_read,
    output logic       hazard
);

    assign hazard = mem_read && (rd != 5'd0) &&
                    ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush scheduler for the five-stage pipeline. Define PIPE_PERF_CNT_EN
// to add the cycle/stall/flush performance counter ports.
//
// state       | meaning
// ST_RUN      | pipeline advancing; a miss in MA freezes it this same cycle
// ST_MEM_WAIT | frozen, waiting for data memory ready
// ST_HALT     | memory timed out; everything held until reset
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       idRs1In,
    input  logic [4:0]       idRs2In,
    input  logic             idUseRs1In,
    input  logic             idUseRs2In,
    input  logic [4:0]       exRdIn,
    input  logic             exMemReadIn,
    input  logic [2:0]       AddrSelectorIn,
    input  logic             lessIn,
    input  logic             zeroIn,
    input  logic             maMemReqIn,
    input  logic             dmemReadyIn,
    output logic             pcWriteOut,
    output logic             ifidWriteOut,
    output logic             idexWriteOut,
    output logic             exmaWriteOut,
    output logic             mawbWriteOut,
    output logic             ifidFlushOut,
    output logic             idexFlushOut,
    output logic             exmaFlushOut,
    output logic             redirectOut,
    output logic [1:0]       stateOut,
    output logic             memTimeoutOut
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycCntOut,
    output logic [CNT_W-1:0] stallCntOut,
    output logic [CNT_W-1:0] flushCntOut
`endif
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 65535 || CNT_W < 1) begin : g_param_check
        $error("pipeline_ctrl: parameter out of range");
    end

    pipe_state_e       state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_timeout;
    logic              taken;
    logic              load_use;
    logic              miss;
    logic              freeze;

    load_use_detect u_load_use (
        .rs1      (idRs1In),
        .rs2      (idRs2In),
        .use_rs1  (idUseRs1In),
        .use_rs2  (idUseRs2In),
        .rd       (exRdIn),
        .mem_read (exMemReadIn),
        .hazard   (load_use)
    );

    assign taken  = branch_taken(AddrSelectorIn, lessIn, zeroIn);
    assign miss   = maMemReqIn && !dmemReadyIn;
    // The ready cycle in MEM_WAIT is not frozen: the access completes and the
    // pipeline advances at that edge.
    assign freeze = ((state == ST_RUN) && miss) ||
                    ((state == ST_MEM_WAIT) && !dmemReadyIn);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (miss) begin
                        wait_cnt <= WAIT_W'(1);
                        if (MEM_TIMEOUT == 1) begin
                            state       <= ST_HALT;
                            mem_timeout <= 1'b1;
                        end else begin
                            state <= ST_MEM_WAIT;
                        end
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmemReadyIn) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == WAIT_LAST) begin
                            state       <= ST_HALT;
                            mem_timeout <= 1'b1;
                        end
                    end
                end
                default: state <= ST_HALT;
            endcase
        end
    end

    always_comb begin
        pcWriteOut    = 1'b0;
        ifidWriteOut  = 1'b0;
        idexWriteOut  = 1'b0;
        exmaWriteOut  = 1'b0;
        mawbWriteOut  = 1'b0;
        ifidFlushOut  = 1'b0;
        idexFlushOut  = 1'b0;
        exmaFlushOut  = 1'b0;
        redirectOut   = 1'b0;
        stateOut      = 2'd0;
        memTimeoutOut = 1'b0;
        if (rstn) begin
            stateOut      = state;
            memTimeoutOut = mem_timeout;
            if (state == ST_HALT || freeze) begin
                pcWriteOut = 1'b0;
            end else if (taken) begin
                pcWriteOut   = 1'b1;
                ifidWriteOut = 1'b1;
                idexWriteOut = 1'b1;
                exmaWriteOut = 1'b1;
                mawbWriteOut = 1'b1;
                ifidFlushOut = 1'b1;
                idexFlushOut = 1'b1;
                exmaFlushOut = 1'b1;
                redirectOut  = 1'b1;
            end else if (load_use) begin
                idexWriteOut = 1'b1;
                exmaWriteOut = 1'b1;
                mawbWriteOut = 1'b1;
                idexFlushOut = 1'b1;
            end else begin
                pcWriteOut   = 1'b1;
                ifidWriteOut = 1'b1;
                idexWriteOut = 1'b1;
                exmaWriteOut = 1'b1;
                mawbWriteOut = 1'b1;
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cycCntOut   <= '0;
            stallCntOut <= '0;
            flushCntOut <= '0;
        end else begin
            cycCntOut <= cycCntOut + 1'b1;
            if (!pcWriteOut && state != ST_HALT) stallCntOut <= stallCntOut + 1'b1;
            if (redirectOut) flushCntOut <= flushCntOut + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: three instances (MEM_TIMEOUT 255, 4, 1) share one
// directed stimulus and are checked every cycle against a behavioural model.
module tb_pipeline_ctrl;

    localparam int N  = 3;
    localparam int CW = 4;

    function automatic int to_of(input int g);
        return (g == 0) ? 255 : ((g == 1) ? 4 : 1);
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic [4:0] idRs1In, idRs2In, exRdIn;
    logic       idUseRs1In, idUseRs2In, exMemReadIn;
    logic [2:0] AddrSelectorIn;
    logic       lessIn, zeroIn, maMemReqIn, dmemReadyIn;

    logic [N-1:0] pcw, ifw, idw, exw, maw, fif, fid, fex, red, tmo;
    logic [1:0]   st [N];
`ifdef PIPE_PERF_CNT_EN
    logic [CW-1:0] cyc [N];
    logic [CW-1:0] stc [N];
    logic [CW-1:0] flc [N];
`endif

    for (genvar g = 0; g < N; g++) begin : g_dut
        pipeline_ctrl #(.MEM_TIMEOUT(to_of(g)), .CNT_W(CW)) dut (
            .clk(clk), .rstn(rstn),
            .idRs1In(idRs1In), .idRs2In(idRs2In),
            .idUseRs1In(idUseRs1In), .idUseRs2In(idUseRs2In),
            .exRdIn(exRdIn), .exMemReadIn(exMemReadIn),
            .AddrSelectorIn(AddrSelectorIn), .lessIn(lessIn), .zeroIn(zeroIn),
            .maMemReqIn(maMemReqIn), .dmemReadyIn(dmemReadyIn),
            .pcWriteOut(pcw[g]), .ifidWriteOut(ifw[g]), .idexWriteOut(idw[g]),
            .exmaWriteOut(exw[g]), .mawbWriteOut(maw[g]),
            .ifidFlushOut(fif[g]), .idexFlushOut(fid[g]), .exmaFlushOut(fex[g]),
            .redirectOut(red[g]), .stateOut(st[g]), .memTimeoutOut(tmo[g])
`ifdef PIPE_PERF_CNT_EN
            , .cycCntOut(cyc[g]), .stallCntOut(stc[g]), .flushCntOut(flc[g])
`endif
        );
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Model: count of consecutive not-ready cycles of the current access, and
    // whether the memory has timed out.
    int       m_len  [N];
    bit       m_halt [N];
    bit [CW-1:0] m_cyc [N];
    bit [CW-1:0] m_stc [N];
    bit [CW-1:0] m_flc [N];

    function automatic bit m_taken();
        return (AddrSelectorIn == 3) || (AddrSelectorIn == 4) ||
               (AddrSelectorIn == 1 && lessIn) || (AddrSelectorIn == 2 && zeroIn);
    endfunction

    function automatic bit m_lu();
        bit dep1, dep2;
        dep1 = idUseRs1In && (idRs1In == exRdIn);
        dep2 = idUseRs2In && (idRs2In == exRdIn);
        return exMemReadIn && (exRdIn != 0) && (dep1 || dep2);
    endfunction

    function automatic bit m_stalled(input int i);
        return !m_halt[i] && !dmemReadyIn && (m_len[i] > 0 || maMemReqIn);
    endfunction

    // {pc, ifid, idex, exma, mawb, fl_ifid, fl_idex, fl_exma, redirect, state, timeout}
    function automatic logic [11:0] model_out(input int i);
        logic [1:0] s;
        if (!rstn)       return 12'b0;
        if (m_halt[i])   return 12'b00000_000_0_10_1;
        s = (m_len[i] > 0) ? 2'd1 : 2'd0;
        if (m_stalled(i)) return {9'b0, s, 1'b0};
        if (m_taken())    return {5'b11111, 3'b111, 1'b1, s, 1'b0};
        if (m_lu())       return {5'b00111, 3'b010, 1'b0, s, 1'b0};
        return {5'b11111, 3'b000, 1'b0, s, 1'b0};
    endfunction

    function automatic logic [11:0] got_of(input int i);
        return {pcw[i], ifw[i], idw[i], exw[i], maw[i], fif[i], fid[i], fex[i],
                red[i], st[i], tmo[i]};
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            logic [11:0] e;
            e = model_out(i);
            if (!rstn) begin
                m_len[i] = 0; m_halt[i] = 0;
                m_cyc[i] = 0; m_stc[i] = 0; m_flc[i] = 0;
            end else begin
                m_cyc[i] = m_cyc[i] + 1'b1;
                if (!e[11] && !m_halt[i]) m_stc[i] = m_stc[i] + 1'b1;
                if (e[3]) m_flc[i] = m_flc[i] + 1'b1;
                if (!m_halt[i]) begin
                    if (m_stalled(i)) begin
                        m_len[i] = m_len[i] + 1;
                        if (m_len[i] == to_of(i)) m_halt[i] = 1;
                    end else begin
                        m_len[i] = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (got_of(i) !== model_out(i)) begin
                n_bad++;
                $display("FAIL outputs inst%0d t=%0t: got %b want %b", i, $time,
                         got_of(i), model_out(i));
            end
`ifdef PIPE_PERF_CNT_EN
            n_cmp++;
            if ({cyc[i], stc[i], flc[i]} !== {m_cyc[i], m_stc[i], m_flc[i]}) begin
                n_bad++;
                $display("FAIL perf inst%0d t=%0t: got cyc/stall/flush %0d/%0d/%0d want %0d/%0d/%0d",
                         i, $time, cyc[i], stc[i], flc[i], m_cyc[i], m_stc[i], m_flc[i]);
            end
`endif
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        idRs1In = 0; idRs2In = 0; idUseRs1In = 0; idUseRs2In = 0;
        exRdIn = 0; exMemReadIn = 0; AddrSelectorIn = 0;
        lessIn = 0; zeroIn = 0; maMemReqIn = 0; dmemReadyIn = 0;
    endtask

    task automatic set_load_use();
        exMemReadIn = 1; exRdIn = 5; idRs1In = 3; idUseRs1In = 1;
        idRs2In = 5; idUseRs2In = 1;
    endtask

    initial begin
        rstn = 0;
        idle();
        tick(); tick();
        @(negedge clk);
        chk("rst_pcw", pcw[0], 0);
        chk("rst_state", st[1], 0);
        chk("rst_timeout", tmo[2], 0);
        tick();
        rstn = 1;
        tick(); tick();

        // beq taken
        AddrSelectorIn = 2; zeroIn = 1;
        @(negedge clk);
        chk("beq_redirect", red[0], 1);
        chk("beq_flush", {fif[0], fid[0], fex[0]}, 7);
        chk("beq_en", {pcw[0], ifw[0], idw[0], exw[0], maw[0]}, 31);
        chk("beq_state", st[0], 0);
        tick(); idle();

        // load-use, then same with rd = x0
        set_load_use();
        @(negedge clk);
        chk("lu_pcw", pcw[0], 0);
        chk("lu_ifw", ifw[0], 0);
        chk("lu_flush", fid[0], 1);
        chk("lu_idw", idw[0], 1);
        tick();
        exRdIn = 0; idRs2In = 0;
        @(negedge clk);
        chk("lu_x0_pcw", pcw[0], 1);
        chk("lu_x0_flush", fid[0], 0);
        tick(); idle();

        // zero-wait access
        maMemReqIn = 1; dmemReadyIn = 1;
        @(negedge clk);
        chk("zw_pcw", pcw[0], 1);
        tick();
        @(negedge clk);
        chk("zw_state", st[0], 0);
        tick();

        // 3 not-ready cycles, then ready
        dmemReadyIn = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("miss_pcw", pcw[0], 0);
            chk("miss_maw", maw[0], 0);
            chk("miss_state", st[0], (k == 0) ? 0 : 1);
            tick();
        end
        dmemReadyIn = 1;
        @(negedge clk);
        chk("resume_en", {pcw[0], ifw[0], idw[0], exw[0], maw[0]}, 31);
        chk("resume_state", st[0], 1);
        tick(); idle();
        @(negedge clk);
        chk("resume_run", st[0], 0);
        chk("to1_halt", st[2], 2);
        chk("to1_flag", tmo[2], 1);
        tick();
        rstn = 0; tick(); rstn = 1;

        // timeout with MEM_TIMEOUT=4
        maMemReqIn = 1; dmemReadyIn = 0;
        repeat (4) tick();
        @(negedge clk);
        chk("to4_state", st[1], 2);
        chk("to4_flag", tmo[1], 1);
        chk("to255_state", st[0], 1);
        tick();
        dmemReadyIn = 1;
        @(negedge clk);
        chk("halt_frozen_pcw", pcw[1], 0);
        chk("halt_state", st[1], 2);
        tick();
        rstn = 0;
        @(negedge clk);
        chk("halt_rst_flag", tmo[1], 0);
        tick();
        rstn = 1; idle();
        @(negedge clk);
        chk("halt_clr_state", st[1], 0);
        chk("halt_clr_flag", tmo[1], 0);
        chk("halt_clr_pcw", pcw[1], 1);
        tick();

        // jal over load-use
        set_load_use(); AddrSelectorIn = 3;
        @(negedge clk);
        chk("jal_redirect", red[0], 1);
        chk("jal_pcw", pcw[0], 1);
        chk("jal_idex_flush", fid[0], 1);
        tick(); idle();
        AddrSelectorIn = 6; lessIn = 1; zeroIn = 1;
        @(negedge clk);
        chk("sel6_redirect", red[0], 0);
        chk("sel6_flush", fif[0], 0);
        tick();
        AddrSelectorIn = 1; lessIn = 0; tick();
        lessIn = 1; tick();
        AddrSelectorIn = 4; tick();
        AddrSelectorIn = 7; tick();
        idle();

        // taken held during a freeze, applied on the ready cycle
        AddrSelectorIn = 2; zeroIn = 1; maMemReqIn = 1;
        @(negedge clk);
        chk("frz_taken_hold", red[0], 0);
        tick(); tick();
        dmemReadyIn = 1;
        @(negedge clk);
        chk("frz_taken_apply", red[0], 1);
        tick(); idle();
        tick();

        // perf counters wrap after 20 cycles
        rstn = 0; tick(); rstn = 1;
        repeat (20) tick();
`ifdef PIPE_PERF_CNT_EN
        @(negedge clk);
        chk("cyc_wrap", cyc[0], 4);
`endif
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
